// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-requester round-robin arbiter.
package arb_pkg;

   localparam int N_REQ = 8;
   localparam int IDX_W = 3;

   typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

   typedef logic [IDX_W-1:0] arb_idx_t;

endpackage

// File: rtl/onehot_enc8.sv
// Combinational 8-to-3 encoder, OR-gate form.
// Output bit b is the OR of every input whose position has bit b set.
// An all-zero input encodes to 0; for a one-hot input the result is its position.
module onehot_enc8
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] sel,
   output arb_idx_t         idx
);

   for (genvar gi = 0; gi < IDX_W; gi++) begin : g_bit
      logic [N_REQ-1:0] contrib;
      for (genvar gj = 0; gj < N_REQ; gj++) begin : g_in
         // Keep only the inputs whose position has bit gi set
         assign contrib[gj] = (((gj >> gi) & 1) != 0) ? sel[gj] : 1'b0;
      end
      assign idx[gi] = |contrib;
   end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant and index.
// A grant is held until the owner raises done or drops its request. Priority
// then rotates to the requester just past the owner.
// Optional feature macro ARB_TIMEOUT_EN: forces a release after HOLD_MAX
// cycles of holding and pulses timeout for one cycle when that happens.
module rr_arbiter8
   import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
   parameter int HOLD_MAX = 16
)
`endif
(
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic [N_REQ-1:0] gnt,
   output arb_idx_t         gnt_idx,
   output logic             gnt_vld,
   output logic             timeout
);

   arb_state_t       state_reg, state_next;
   arb_idx_t         ptr_reg, ptr_next;
   logic [N_REQ-1:0] gnt_reg, gnt_next;
   arb_idx_t         idx_reg, idx_next;
   logic             vld_reg, vld_next;

   logic [N_REQ-1:0] below_ptr;
   logic [N_REQ-1:0] req_upper;
   logic [N_REQ-1:0] pick;
   logic             owner_release;

   // Priority select: first look at requesters at or above ptr. If none of
   // those are requesting, wrap around to the lowest requester overall.
   // x & -x isolates the lowest set bit, which gives the one-hot winner directly.
   assign below_ptr = (N_REQ'(1) << ptr_reg) - N_REQ'(1);
   assign req_upper = req & ~below_ptr;
   assign pick      = (|req_upper) ? (req_upper & (~req_upper + N_REQ'(1)))
                                   : (req & (~req + N_REQ'(1)));

   // Owner lets go either explicitly or by withdrawing its request
   assign owner_release = done | ~req[idx_reg];

   // Index of the next grant comes from encoding the next-grant vector,
   // so it is 0 whenever no grant is scheduled.
   onehot_enc8 u_enc (
      .sel (gnt_next),
      .idx (idx_next)
   );

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

   logic [7:0] hold_reg, hold_next;
   logic       timeout_reg, timeout_next;
`endif

   // Next-state, next-grant and pointer-update logic
   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      gnt_next   = gnt_reg;
`ifdef ARB_TIMEOUT_EN
      hold_next    = hold_reg;
      timeout_next = 1'b0;
`endif
      case (state_reg)
         ARB_IDLE: begin
            if (|req) begin
               gnt_next   = pick;
               state_next = ARB_GRANT;
`ifdef ARB_TIMEOUT_EN
               hold_next  = 8'd0;
`endif
            end
         end
         ARB_GRANT: begin
            if (owner_release) begin
               gnt_next   = '0;
               ptr_next   = idx_reg + 3'd1;
               state_next = ARB_IDLE;
            end
`ifdef ARB_TIMEOUT_EN
            else if (hold_reg == HOLD_LAST) begin
               // Held too long: release exactly like a normal release, and flag it
               gnt_next     = '0;
               ptr_next     = idx_reg + 3'd1;
               state_next   = ARB_IDLE;
               timeout_next = 1'b1;
            end else begin
               hold_next = hold_reg + 8'd1;
            end
`endif
         end
      endcase
      vld_next = |gnt_next;
   end

   // State, pointer and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ARB_IDLE;
         ptr_reg   <= '0;
         gnt_reg   <= '0;
         idx_reg   <= '0;
         vld_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         gnt_reg   <= gnt_next;
         idx_reg   <= idx_next;
         vld_reg   <= vld_next;
      end
   end

`ifdef ARB_TIMEOUT_EN
   // Hold counter and timeout pulse register
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_reg    <= 8'd0;
         timeout_reg <= 1'b0;
      end else begin
         hold_reg    <= hold_next;
         timeout_reg <= timeout_next;
      end
   end

   assign timeout = timeout_reg;
`else
   assign timeout = 1'b0;
`endif

   assign gnt     = gnt_reg;
   assign gnt_idx = idx_reg;
   assign gnt_vld = vld_reg;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Testbench for rr_arbiter8: directed scenarios followed by random traffic,
// all checked each cycle against a behavioural round-robin model.
// Build with ARB_TIMEOUT_EN defined to exercise the hold timeout (HOLD_MAX=4).
module tb_rr_arbiter8;

   localparam int HOLD_MAX = 4;
`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_vld;
   logic       timeout;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model state: who owns the resource, how long, next priority
   bit m_busy;
   int m_owner;
   int m_ptr;
   int m_held;
   bit m_to;

   always #5 clk = ~clk;

`ifdef ARB_TIMEOUT_EN
   rr_arbiter8 #(.HOLD_MAX(HOLD_MAX)) dut (
`else
   rr_arbiter8 dut (
`endif
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .done    (done),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld),
      .timeout (timeout)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Advance the model by one clock edge given the inputs sampled at that edge
   task automatic model_step(input logic r, input logic [7:0] q, input logic d);
      bit rel;
      bit timed;
      int c;
      if (r) begin
         m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_to = 0;
      end else if (!m_busy) begin
         m_to = 0;
         if (q != 8'h00) begin
            for (int k = 0; k < 8; k++) begin
               c = (m_ptr + k) % 8;
               if (q[c]) begin
                  m_owner = c;
                  break;
               end
            end
            m_busy = 1;
            m_held = 1;
         end
      end else begin
         rel   = d || !q[m_owner];
         timed = TO_EN && (m_held >= HOLD_MAX);
         m_to  = timed && !rel;
         if (rel || timed) begin
            m_busy = 0;
            m_ptr  = (m_owner + 1) % 8;
         end else begin
            m_held++;
         end
      end
   endtask

   // Drive one cycle of inputs, step the model, then compare on the falling edge
   task automatic cycle(input logic r, input logic [7:0] q, input logic d);
      logic [7:0] e_gnt;
      rst  = r;
      req  = q;
      done = d;
      model_step(r, q, d);
      @(negedge clk);
      e_gnt = m_busy ? (8'h01 << m_owner) : 8'h00;
      check_eq("gnt", gnt, e_gnt);
      check_eq("gnt_idx", gnt_idx, m_busy ? m_owner : 0);
      check_eq("gnt_vld", gnt_vld, m_busy);
      check_eq("timeout", timeout, m_to);
      $display("cyc rst=%0b req=%02h done=%0b -> gnt=%02h idx=%0d vld=%0b to=%0b",
               r, q, d, gnt, gnt_idx, gnt_vld, timeout);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] rq;
      rst  = 1'b1;
      req  = 8'h00;
      done = 1'b0;
      m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_to = 0;
      @(negedge clk);

      // 1: reset held with all requests up, then first grant goes to 0
      cycle(1, 8'hFF, 0);
      cycle(1, 8'hFF, 0);
      cycle(0, 8'hFF, 0);
      check_eq("t1_first_idx", gnt_idx, 0);
      cycle(0, 8'hFF, 1);

      // 2: single requester 0, grant then release on done
      cycle(0, 8'h01, 0);
      check_eq("t2_gnt", gnt, 8'h01);
      cycle(0, 8'h01, 1);
      check_eq("t2_rel_vld", gnt_vld, 0);
      cycle(0, 8'h00, 0);

      // 3: all requesting, done each grant -> indices rotate 0..7,0
      cycle(1, 8'h00, 0);
      for (int k = 0; k < 9; k++) begin
         cycle(0, 8'hFF, 0);
         check_eq("t3_seq", gnt_idx, k % 8);
         cycle(0, 8'hFF, 1);
         check_eq("t3_idle", gnt_vld, 0);
      end

      // 4: after owner 4 releases, {3,0} requesting -> 0 wins by wrap, then 3
      cycle(1, 8'h00, 0);
      cycle(0, 8'h10, 0);
      cycle(0, 8'h10, 1);
      cycle(0, 8'h09, 0);
      check_eq("t4_wrap", gnt_idx, 0);
      cycle(0, 8'h09, 1);
      cycle(0, 8'h09, 0);
      check_eq("t4_next", gnt_idx, 3);
      cycle(0, 8'h09, 1);

      // 5: a held grant with no done; forced release only with the timeout build
      cycle(1, 8'h00, 0);
      cycle(0, 8'h04, 0);
      for (int k = 1; k < HOLD_MAX; k++) begin
         cycle(0, 8'h04, 0);
         check_eq("t5_hold", gnt, 8'h04);
      end
      cycle(0, 8'h04, 0);
      cycle(0, 8'h04, 0);
      check_eq("t5_regrant", gnt_idx, 2);
      cycle(0, 8'h04, 1);

      // 6: reset in the middle of a grant to 5
      cycle(1, 8'h00, 0);
      cycle(0, 8'h20, 0);
      check_eq("t6_gnt", gnt, 8'h20);
      cycle(1, 8'h20, 0);
      check_eq("t6_rst_gnt", gnt, 8'h00);
      cycle(0, 8'h20, 0);
      check_eq("t6_regrant", gnt_idx, 5);

      // Random traffic: requests flip sparsely, done and reset occasional
      rq = 8'h00;
      for (int n = 0; n < 3000; n++) begin
         for (int b = 0; b < 8; b++)
            if ($urandom_range(0, 4) == 0) rq[b] = ~rq[b];
         cycle(($urandom_range(0, 199) == 0), rq, ($urandom_range(0, 3) == 0));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
